// File: rtl/joystick_adc_reader.sv
// Joystick ADC reader: polls a 10-bit SPI ADC (mode 0, 24-clock frames),
// alternating between the X and Y channels, and publishes registered axis
// values. sample_valid pulses together with each new Y value.
// Optional build macro: JOY_ADC_AVG_EN -- 4-sample moving average per axis.
module joystick_adc_reader #(
    parameter int unsigned CLK_DIV    = 25,
    parameter logic [2:0]  X_CH       = 3'd0,
    parameter logic [2:0]  Y_CH       = 3'd1,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       adc_miso,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_mosi,
    output logic [9:0] x_axis_out,
    output logic [9:0] y_axis_out,
    output logic       sample_valid
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [9:0]       CENTRE   = 10'd512;

    typedef enum logic [2:0] {
        S_GAP,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_UPDATE
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [4:0]       bit_cnt_q;    // current SCLK period, 1..24
    logic [9:0]       shift_q;      // result bits captured on edges 15..24
    logic             ch_y_q;       // 0: X frame, 1: Y frame
    logic             cs_n_q;
    logic             sclk_q;
    logic             mosi_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic             valid_q;

    logic [2:0]       cur_ch;
    logic [9:0]       x_new_d;
    logic [9:0]       y_new_d;

    assign cur_ch       = ch_y_q ? Y_CH : X_CH;
    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_mosi     = mosi_q;
    assign x_axis_out   = x_q;
    assign y_axis_out   = y_q;
    assign sample_valid = valid_q;

    // Command frame: start bit at 8, single-ended at 9, channel at 10..12.
    function automatic logic frame_bit(input logic [4:0] n, input logic [2:0] ch);
        logic b;
        case (n)
            5'd8, 5'd9: b = 1'b1;
            5'd10:      b = ch[2];
            5'd11:      b = ch[1];
            5'd12:      b = ch[0];
            default:    b = 1'b0;
        endcase
        return b;
    endfunction

`ifdef JOY_ADC_AVG_EN
    logic [9:0]  x_hist_q [4];
    logic [9:0]  y_hist_q [4];
    logic [1:0]  x_ptr_q;
    logic [1:0]  y_ptr_q;
    logic [11:0] x_sum;
    logic [11:0] y_sum;

    // Average of the history with the oldest entry replaced by the new result.
    always_comb begin
        x_sum = '0;
        y_sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            x_sum = x_sum + ((x_ptr_q == 2'(i)) ? {2'b00, shift_q} : {2'b00, x_hist_q[i]});
            y_sum = y_sum + ((y_ptr_q == 2'(i)) ? {2'b00, shift_q} : {2'b00, y_hist_q[i]});
        end
        x_new_d = x_sum[11:2];
        y_new_d = y_sum[11:2];
    end

    // History rings: overwrite the oldest entry of the axis just converted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                x_hist_q[i] <= CENTRE;
                y_hist_q[i] <= CENTRE;
            end
            x_ptr_q <= '0;
            y_ptr_q <= '0;
        end else if (state_q == S_UPDATE) begin
            if (ch_y_q) begin
                y_hist_q[y_ptr_q] <= shift_q;
                y_ptr_q           <= y_ptr_q + 2'd1;
            end else begin
                x_hist_q[x_ptr_q] <= shift_q;
                x_ptr_q           <= x_ptr_q + 2'd1;
            end
        end
    end
`else
    // Raw result of the latest frame goes straight to the axis output.
    always_comb begin
        x_new_d = shift_q;
        y_new_d = shift_q;
    end
`endif

    // Frame sequencer with registered SPI pins and axis outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_GAP;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ch_y_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            x_q       <= CENTRE;
            y_q       <= CENTRE;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_GAP: begin
                    cs_n_q <= 1'b1;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (gap_cnt_q == GAP_LAST) begin
                        // Counter stays saturated while en is low.
                        if (en) begin
                            state_q   <= S_SETUP;
                            gap_cnt_q <= '0;
                            div_cnt_q <= '0;
                            bit_cnt_q <= 5'd1;
                            shift_q   <= '0;
                            cs_n_q    <= 1'b0;
                            mosi_q    <= frame_bit(5'd1, cur_ch);
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        state_q   <= S_SHIFT;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (bit_cnt_q >= 5'd15) begin
                                shift_q <= {shift_q[8:0], adc_miso};
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == 5'd24) begin
                                state_q <= S_HOLD;
                                mosi_q  <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                mosi_q    <= frame_bit(bit_cnt_q + 5'd1, cur_ch);
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        cs_n_q    <= 1'b1;
                        state_q   <= S_UPDATE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (ch_y_q) begin
                        y_q     <= y_new_d;
                        valid_q <= 1'b1;
                    end else begin
                        x_q <= x_new_d;
                    end
                    ch_y_q    <= ~ch_y_q;
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                end
                default: begin
                    state_q <= S_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Directed bench for joystick_adc_reader (CLK_DIV=2, GAP_CYCLES=4) with a
// behavioural 10-bit SPI ADC that decodes the channel from the command bits.
module tb_joystick_adc_reader;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 4;

`ifdef JOY_ADC_AVG_EN
    localparam int X_PAIR1   = 639;   // (3*512 + 1023) >> 2
    localparam int Y_PAIR1   = 384;   // (3*512 + 0) >> 2
    localparam int X_SEQ [4] = '{384, 256, 128, 0};
    localparam int Y_DROP    = 469;   // (3*512 + 341) >> 2
`else
    localparam int X_PAIR1   = 1023;
    localparam int Y_PAIR1   = 0;
    localparam int X_SEQ [4] = '{0, 0, 0, 0};
    localparam int Y_DROP    = 341;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       adc_miso;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_mosi;
    logic [9:0] x_axis_out;
    logic [9:0] y_axis_out;
    logic       sample_valid;

    joystick_adc_reader #(
        .CLK_DIV   (CLK_DIV),
        .X_CH      (3'd0),
        .Y_CH      (3'd1),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .adc_miso    (adc_miso),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_mosi    (adc_mosi),
        .x_axis_out  (x_axis_out),
        .y_axis_out  (y_axis_out),
        .sample_valid(sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model and bus monitor state
    logic [9:0] ch_val [8];
    logic [9:0] cur_val;
    logic [4:0] cmd;
    int         rise_cnt = 0;
    logic       in_win = 1'b0;
    int         win_idx = 0;
    int         win_rises [32];
    logic [4:0] win_cmd [32];
    int         sv_cnt = 0;
    int         hi_run = 0;
    int         last_hi = 0;

    logic       ok;
    int         low_cnt;
    int         sv_base;

    assign cur_val = ch_val[cmd[2:0]];

    // ADC drives the result bit needed at the next rising edge (edges 15..24).
    always_comb begin
        adc_miso = 1'b1;
        if (rise_cnt >= 14 && rise_cnt <= 23) adc_miso = cur_val[4'(23 - rise_cnt)];
    end

    always @(negedge adc_cs_n) begin
        rise_cnt = 0;
        cmd      = '0;
        in_win   = 1'b1;
    end

    always @(posedge adc_sclk) begin
        rise_cnt = rise_cnt + 1;
        if (rise_cnt >= 8 && rise_cnt <= 12) cmd = {cmd[3:0], adc_mosi};
    end

    always @(posedge adc_cs_n) begin
        if (in_win) begin
            if (win_idx < 32) begin
                win_rises[win_idx] = rise_cnt;
                win_cmd[win_idx]   = cmd;
            end
            win_idx = win_idx + 1;
            in_win  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (sample_valid) sv_cnt = sv_cnt + 1;
        if (adc_cs_n) begin
            hi_run = hi_run + 1;
        end else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_win(input int target, input string tag);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (win_idx >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ch_val[i] = 10'h2AA;
        ch_val[0] = 10'h3FF;
        ch_val[1] = 10'h000;
        rst_n = 1'b0;
        en    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cs_n",  32'(adc_cs_n), 32'd1);
        check("rst_sclk",  32'(adc_sclk), 32'd0);
        check("rst_mosi",  32'(adc_mosi), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_x",     32'(x_axis_out), 32'd512);
        check("rst_y",     32'(y_axis_out), 32'd512);

        // First X/Y pair: ch0 full scale, ch1 zero
        rst_n = 1'b1;
        en    = 1'b1;
        wait_win(1, "wait_x1");
        check("x_latency_old", 32'(x_axis_out), 32'd512);
        @(negedge clk);
        check("x_latency_new", 32'(x_axis_out), 32'(X_PAIR1));
        check("no_valid_on_x", 32'(sample_valid), 32'd0);
        wait_valid("wait_valid1");
        check("y_pair1", 32'(y_axis_out), 32'(Y_PAIR1));
        check("x_pair1_hold", 32'(x_axis_out), 32'(X_PAIR1));
        @(negedge clk);
        check("valid_one_cycle", 32'(sample_valid), 32'd0);
        check("valid_count1", 32'(sv_cnt), 32'd1);
        check("win0_rises", 32'(win_rises[0]), 32'd24);
        check("win0_cmd",   32'(win_cmd[0]), 32'b11000);
        check("win1_rises", 32'(win_rises[1]), 32'd24);
        check("win1_cmd",   32'(win_cmd[1]), 32'b11001);
        check("gap_len",    32'(last_hi), 32'(GAP_CYCLES + 1));

        // Reset at SCLK rising edge 12 of the next Y frame (window 3)
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (win_idx == 3 && in_win && rise_cnt == 12) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_edge12", 32'(ok), 32'd1);
        check("sclk_high_edge12", 32'(adc_sclk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n",  32'(adc_cs_n), 32'd1);
        check("mid_rst_sclk",  32'(adc_sclk), 32'd0);
        check("mid_rst_mosi",  32'(adc_mosi), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_x",     32'(x_axis_out), 32'd512);
        check("mid_rst_y",     32'(y_axis_out), 32'd512);
        check("mid_rst_win",   32'(win_idx), 32'd4);
        ch_val[0] = 10'h000;
        ch_val[1] = 10'd512;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Four X/Y pairs after reset; first frame must be X
        sv_base = sv_cnt;
        for (int k = 0; k < 4; k++) begin
            wait_win(5 + 2 * k, "wait_xk");
            repeat (2) @(negedge clk);
            check("xk_value", 32'(x_axis_out), 32'(X_SEQ[k]));
            check("xk_cmd",   32'(win_cmd[4 + 2 * k]), 32'b11000);
            check("xk_rises", 32'(win_rises[4 + 2 * k]), 32'd24);
            check("xk_no_valid", 32'(sv_cnt), 32'(sv_base));
            wait_win(6 + 2 * k, "wait_yk");
            repeat (2) @(negedge clk);
            check("yk_value", 32'(y_axis_out), 32'd512);
            check("yk_cmd",   32'(win_cmd[5 + 2 * k]), 32'b11001);
            check("yk_valid", 32'(sv_cnt), 32'(sv_base + 1));
            sv_base = sv_cnt;
        end

        // Drop en at SCLK edge 5 of the Y frame (window 13)
        ch_val[1] = 10'h155;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (win_idx == 13 && in_win && rise_cnt == 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_edge5", 32'(ok), 32'd1);
        en = 1'b0;
        wait_valid("wait_valid_drop");
        check("y_drop", 32'(y_axis_out), 32'(Y_DROP));
        @(negedge clk);
        check("valid_drop_one_cycle", 32'(sample_valid), 32'd0);
        check("win13_rises", 32'(win_rises[13]), 32'd24);
        low_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!adc_cs_n) low_cnt++;
        end
        check("parked_cs_n_low_cycles", 32'(low_cnt), 32'd0);
        check("parked_win", 32'(win_idx), 32'd14);
        check("valid_total", 32'(sv_cnt), 32'd6);

        // en returns: next frame is X
        en = 1'b1;
        wait_win(15, "wait_resume");
        check("resume_cmd",   32'(win_cmd[14]), 32'b11000);
        check("resume_rises", 32'(win_rises[14]), 32'd24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
